// File: rtl/blackjack_wager_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// blackjack_wager_ctrl_pkg
// Shared constants for the Blackjack wager/bankroll controller:
//   - hand result codes reported by the game FSM
//   - bet increment amounts for the four bet buttons
//   - wager FSM state encoding (legacy-compatible constants)
// Optional feature macro used by the controller: WAGER_BANKROLL_CAP_EN
// ----------------------------------------------------------------------------
package blackjack_wager_ctrl_pkg;

    // Hand results; codes 5..7 are settled as a tie
    localparam logic [2:0] RES_LOST      = 3'd0;
    localparam logic [2:0] RES_BUST      = 3'd1;
    localparam logic [2:0] RES_TIE       = 3'd2;
    localparam logic [2:0] RES_WIN       = 3'd3;
    localparam logic [2:0] RES_BLACKJACK = 3'd4;

    // Button amounts; all four together sum to 41
    localparam logic [5:0] AMT_1  = 6'd1;
    localparam logic [5:0] AMT_5  = 6'd5;
    localparam logic [5:0] AMT_10 = 6'd10;
    localparam logic [5:0] AMT_25 = 6'd25;

    // Wager FSM states
    localparam logic [1:0] ST_OPEN   = 2'd0;
    localparam logic [1:0] ST_LOCKED = 2'd1;
    localparam logic [1:0] ST_SETTLE = 2'd2;

endpackage

// File: rtl/blackjack_wager_ctrl_if.sv
// ----------------------------------------------------------------------------
// blackjack_wager_ctrl_if
// Bundle between the game side (master) and the wager controller (slave).
//   increment_1/5/10/25  bet button levels (debounced, clk-synchronous)
//   deal_req             hand starts, lock the bet
//   result_valid         hand finished, result_code valid
//   result_code[2:0]     LOST/BUST/TIE/WIN/BLACKJACK
//   bet[6:0]             current wager
//   bankroll[BANK_W-1:0] signed bankroll
//   bet_locked           bet frozen (hand in progress or settling)
//   settle_done          one-cycle pulse, bankroll updated
//   broke                bankroll <= 0
// ----------------------------------------------------------------------------
interface blackjack_wager_ctrl_if #(
    parameter int unsigned BANK_W = 11
);
    logic                     increment_1;
    logic                     increment_5;
    logic                     increment_10;
    logic                     increment_25;
    logic                     deal_req;
    logic                     result_valid;
    logic [2:0]               result_code;
    logic [6:0]               bet;
    logic signed [BANK_W-1:0] bankroll;
    logic                     bet_locked;
    logic                     settle_done;
    logic                     broke;

    modport master (
        output increment_1, increment_5, increment_10, increment_25,
        output deal_req, result_valid, result_code,
        input  bet, bankroll, bet_locked, settle_done, broke
    );

    modport slave (
        input  increment_1, increment_5, increment_10, increment_25,
        input  deal_req, result_valid, result_code,
        output bet, bankroll, bet_locked, settle_done, broke
    );
endinterface

// File: rtl/blackjack_wager_ctrl_button_rise_detect.sv
// ----------------------------------------------------------------------------
// button_rise_detect
// One-bit rising-edge detector for a synchronous button level.
//   clk   in   system clock
//   rst   in   synchronous reset, active-high
//   btn   in   button level
//   rise  out  high on the cycle btn is sampled high after being low
// History resets to 1 so a button held through reset never registers.
// ----------------------------------------------------------------------------
module button_rise_detect (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic rise
);
    logic hist_q;

    always_ff @(posedge clk) begin
        if (rst) hist_q <= 1'b1;
        else     hist_q <= btn;
    end

    assign rise = btn & ~hist_q;
endmodule

// File: rtl/blackjack_wager_ctrl.sv
// ----------------------------------------------------------------------------
// blackjack_wager_ctrl
// Wager/bankroll controller beside the Blackjack game FSM. Turns bet button
// edges into a saturating bet, locks it at deal, settles the bankroll from
// the hand result. Sole writer of bet and bankroll.
//   clk   in   system clock
//   rst   in   synchronous reset, active-high
//   bus   slave modport of blackjack_wager_ctrl_if (buttons, deal/result
//         handshake in; bet, bankroll, bet_locked, settle_done, broke out)
// Optional macro WAGER_BANKROLL_CAP_EN: bet ceiling limited by a positive
// bankroll, and no betting or dealing while broke.
// ----------------------------------------------------------------------------
module blackjack_wager_ctrl
    import blackjack_wager_ctrl_pkg::*;
#(
    parameter int          START_BANKROLL = 200,
    parameter int          MAX_BET        = 99,
    parameter int          BANK_LIMIT     = 999,
    parameter int unsigned BANK_W         = 11
) (
    input logic                  clk,
    input logic                  rst,
    blackjack_wager_ctrl_if.slave bus
);
    // Two spare bits so bankroll + 1.5*bet cannot wrap before clamping
    localparam int unsigned WIDE_W = BANK_W + 2;
    localparam logic signed [WIDE_W-1:0] LIM_HI = WIDE_W'(BANK_LIMIT);
    localparam logic signed [WIDE_W-1:0] LIM_LO = -LIM_HI;

    logic [1:0]               state_q;
    logic [6:0]               bet_q;
    logic signed [BANK_W-1:0] bankroll_q;

    logic [3:0] rise;
    logic [5:0] inc_sum;
    logic [7:0] bet_sum;
    logic [7:0] bet_ceil;
    logic [6:0] bet_next;
    logic       broke_w;
    logic       play_ok;
    logic       deal_go;

    logic signed [WIDE_W-1:0] bet_wide;
    logic signed [WIDE_W-1:0] delta;
    logic signed [WIDE_W-1:0] sum_wide;
    logic signed [WIDE_W-1:0] clamped;

    button_rise_detect u_rise_1  (.clk(clk), .rst(rst), .btn(bus.increment_1),  .rise(rise[0]));
    button_rise_detect u_rise_5  (.clk(clk), .rst(rst), .btn(bus.increment_5),  .rise(rise[1]));
    button_rise_detect u_rise_10 (.clk(clk), .rst(rst), .btn(bus.increment_10), .rise(rise[2]));
    button_rise_detect u_rise_25 (.clk(clk), .rst(rst), .btn(bus.increment_25), .rise(rise[3]));

    assign broke_w = (bankroll_q <= 0);

`ifdef WAGER_BANKROLL_CAP_EN
    assign play_ok = ~broke_w;
`else
    assign play_ok = 1'b1;
`endif

    assign deal_go = (state_q == ST_OPEN) && bus.deal_req && (bet_q != '0) && play_ok;

    // Bet adder and saturator
    always_comb begin
        inc_sum = (rise[0] ? AMT_1  : '0) + (rise[1] ? AMT_5  : '0)
                + (rise[2] ? AMT_10 : '0) + (rise[3] ? AMT_25 : '0);
        bet_sum = {1'b0, bet_q} + {2'b0, inc_sum};
        bet_ceil = 8'(MAX_BET);
`ifdef WAGER_BANKROLL_CAP_EN
        if ((bankroll_q > 0) && (bankroll_q < MAX_BET))
            bet_ceil = 8'(bankroll_q);
`endif
        bet_next = (bet_sum > bet_ceil) ? bet_ceil[6:0] : bet_sum[6:0];
    end

    // Settlement arithmetic, evaluated against the live result_code
    always_comb begin
        bet_wide = $signed(WIDE_W'(bet_q));
        case (bus.result_code)
            RES_LOST, RES_BUST: delta = -bet_wide;
            RES_WIN:            delta = bet_wide;
            RES_BLACKJACK:      delta = bet_wide + (bet_wide >>> 1);
            default:            delta = '0;
        endcase
        sum_wide = WIDE_W'(bankroll_q) + delta;
        if (sum_wide > LIM_HI)      clamped = LIM_HI;
        else if (sum_wide < LIM_LO) clamped = LIM_LO;
        else                        clamped = sum_wide;
    end

    // The bankroll is written on the LOCKED->SETTLE edge so it is already
    // updated while settle_done is high during the single SETTLE cycle;
    // the bet is cleared on the way back to OPEN.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_OPEN;
            bet_q      <= '0;
            bankroll_q <= BANK_W'(START_BANKROLL);
        end else begin
            case (state_q)
                ST_OPEN: begin
                    if (deal_go)      state_q <= ST_LOCKED;
                    else if (play_ok) bet_q   <= bet_next;
                end
                ST_LOCKED: begin
                    if (bus.result_valid) begin
                        state_q    <= ST_SETTLE;
                        bankroll_q <= BANK_W'(clamped);
                    end
                end
                ST_SETTLE: begin
                    bet_q   <= '0;
                    state_q <= ST_OPEN;
                end
                default: state_q <= ST_OPEN;
            endcase
        end
    end

    assign bus.bet         = bet_q;
    assign bus.bankroll    = bankroll_q;
    assign bus.bet_locked  = (state_q == ST_LOCKED) || (state_q == ST_SETTLE);
    assign bus.settle_done = (state_q == ST_SETTLE);
    assign bus.broke       = broke_w;
endmodule
